mult_unit: RTL and testbench

Iterative shift-add multiplier that consumes the controller's start_mult/mult_sign command.
- Executes MULT (signed) and MULTU (unsigned) on two WIDTH-bit register operands.
- Produces the 2*WIDTH-bit product into architectural HI/LO registers, which the output mux reads for MFHI/MFLO.
- Provides busy/done status so the pipeline can stall MFHI/MFLO until the result is ready.

---
 rtl/mult_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
//
// Purpose:
//   Iterative shift-add multiplier for the MULT (signed) and MULTU (unsigned)
//   instructions. Each operation retires one multiplier bit per clock. The
//   2*WIDTH-bit product lands in the architectural HI/LO registers, which the
//   output mux reads for MFHI/MFLO. The busy/done status lets the pipeline
//   stall MFHI/MFLO until a result is ready.
//
//   Signed operands are converted to magnitudes before the loop. The sign of
//   the product is applied once, when the result is latched.
//
// Configuration:
//   MULT_EARLY_TERM_EN - when defined, the loop ends as soon as no set bits
//                        remain in the multiplier. Latency becomes the
//                        position of the highest set bit of |b| plus one,
//                        with a minimum of one cycle. When undefined, every
//                        operation takes exactly WIDTH cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   start_mult  in   one-cycle command pulse from the control unit
//   mult_sign   in   1 = signed (MULT), 0 = unsigned (MULTU)
//   operand_a   in   rs data, WIDTH bits
//   operand_b   in   rt data, WIDTH bits
//   hi          out  upper half of the last completed product
//   lo          out  lower half of the last completed product
//   busy        out  high while the iteration loop is running
//   done        out  one-cycle pulse while hi/lo first show a new result
// ---------------------------------------------------------------------------
module mult_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [CNT_W-1:0]   cnt;
   logic               sign_op;
   logic               sign_diff;
   logic               neg;
   logic               accept;
   logic               last_iter;

   // A new command is taken in IDLE or DONE. A start that arrives while the
   // loop runs is dropped, so the operation in flight is never disturbed.
   assign accept = start_mult && (state != CALC);

   // Magnitudes of the operands. The most negative value maps onto itself,
   // and that bit pattern reads correctly as an unsigned magnitude.
   assign mag_a = (mult_sign && operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign mag_b = (mult_sign && operand_b[WIDTH-1]) ? -operand_b : operand_b;

   // The product is negative only for a signed operation whose operand
   // signs differed.
   assign neg = sign_op & sign_diff;

   // One shift-add step. The final sign is applied to the step's result, so
   // the last iteration can be latched directly into HI/LO.
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
      result   = neg ? -acc_next : acc_next;
   end

   // Decide whether this CALC cycle is the final iteration. With early
   // termination, the loop also stops once the remaining multiplier bits
   // are all zero. The product is already complete at that point.
`ifdef MULT_EARLY_TERM_EN
   assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DONE lasts one cycle. It behaves like IDLE for a new
   // start, so back-to-back multiplies need no idle gap.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = accept ? CALC : IDLE;
         CALC:    state_next = last_iter ? DONE : CALC;
         DONE:    state_next = accept ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs decode directly from the state.
   always_comb begin
      busy = (state == CALC);
      done = (state == DONE);
   end

   // Datapath. Operands are captured on an accepted start. Each CALC cycle
   // performs one step. HI/LO change only when the final step completes, so
   // they otherwise hold the previous product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         sign_op   <= 1'b0;
         sign_diff <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else if (accept) begin
         mcand     <= {{WIDTH{1'b0}}, mag_a};
         mplier    <= mag_b;
         acc       <= '0;
         cnt       <= '0;
         sign_op   <= mult_sign;
         sign_diff <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      end else if (state == CALC) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (last_iter) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit
//
// Self-checking bench for mult_unit. A table of directed multiplies with
// hand-computed products and latencies is run first. Short sequences follow
// for a start issued while busy and for a reset asserted mid-operation.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult_unit;

   localparam int WIDTH = 32;
   localparam int NVEC  = 11;
   localparam int BOUND = 100;

   logic             clk;
   logic             rst;
   logic             start_mult;
   logic             mult_sign;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   int checks;
   int errors;

   typedef struct {
      logic        sign;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat_early;
   } vec_t;

   vec_t vecs [NVEC];

   mult_unit #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Return the expected latency for the build under test.
   function automatic int expLat(input int lat_early);
`ifdef MULT_EARLY_TERM_EN
      return lat_early;
`else
      return (lat_early > 0) ? WIDTH : 0;
`endif
   endfunction

   // Drive the command inputs.
   task automatic applyStimulus(input logic s, input logic sign,
                                input logic [31:0] a, input logic [31:0] b);
      start_mult = s;
      mult_sign  = sign;
      operand_a  = a;
      operand_b  = b;
   endtask

   // Compare one value and report any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Issue one multiply and wait, with a cycle bound, for done. The latency
   // is the number of rising edges from the start edge to the edge that
   // raised done.
   task automatic runOp(input logic sign, input logic [31:0] a,
                        input logic [31:0] b, output logic [63:0] prod,
                        output int lat, output int busy_cycles,
                        output bit timeout);
      prod        = '0;
      lat         = 0;
      busy_cycles = 0;
      timeout     = 1'b1;
      applyStimulus(1'b1, sign, a, b);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (busy) busy_cycles++;
      for (int k = 1; k <= BOUND; k++) begin
         @(negedge clk);
         if (done) begin
            lat     = k;
            prod    = {hi, lo};
            timeout = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
      end
   endtask

   initial begin
      logic [63:0] prod;
      logic [63:0] prior;
      int          lat;
      int          bcnt;
      bit          tmo;
      int          done_cnt;
      int          first_done;
      bit          hold_bad;
      logic [31:0] busy_b;
      logic [63:0] busy_exp;
      int          busy_lat;

      checks = 0;
      errors = 0;

      //          sign  a             b             hi            lo            early lat
      vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32};
      vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 3};
      vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32};
      vecs[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 2};
      vecs[5]  = '{1'b0, 32'h00000007, 32'h00000003, 32'h00000000, 32'h00000015, 2};
      vecs[6]  = '{1'b0, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1};
      vecs[7]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 2};
      vecs[8]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
      vecs[9]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A, 3};
      vecs[10] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1};

      // Reset state, both during and after reset.
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("reset_hilo", {hi, lo}, 64'h0);
      checkOutput("reset_status", {62'h0, busy, done}, 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle_hilo", {hi, lo}, 64'h0);
      checkOutput("idle_status", {62'h0, busy, done}, 64'h0);

      // Table-driven multiplies.
      for (int i = 0; i < NVEC; i++) begin
         runOp(vecs[i].sign, vecs[i].a, vecs[i].b, prod, lat, bcnt, tmo);
         checkOutput($sformatf("v%0d_timeout", i), {63'h0, tmo}, 64'h0);
         checkOutput($sformatf("v%0d_product", i), prod, {vecs[i].exp_hi, vecs[i].exp_lo});
         checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(expLat(vecs[i].lat_early)));
         checkOutput($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(expLat(vecs[i].lat_early)));
         @(negedge clk);
         checkOutput($sformatf("v%0d_done_width", i), {63'h0, done}, 64'h0);
      end

      // A start pulse issued while busy must be ignored. In early-terminate
      // builds, 7x3 finishes before cycle 5, so a wider multiplier keeps the
      // loop running.
`ifdef MULT_EARLY_TERM_EN
      busy_b   = 32'h00010003;
      busy_exp = 64'h0000000000070015;
      busy_lat = 17;
`else
      busy_b   = 32'h00000003;
      busy_exp = 64'h0000000000000015;
      busy_lat = 32;
`endif
      prior      = {hi, lo};
      done_cnt   = 0;
      first_done = 0;
      hold_bad   = 1'b0;
      prod       = '0;
      applyStimulus(1'b1, 1'b0, 32'h7, busy_b);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 5) applyStimulus(1'b1, 1'b0, 32'h9, 32'h9);
         if (k == 6) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
         if (done) begin
            done_cnt++;
            if (first_done == 0) begin
               first_done = k;
               prod       = {hi, lo};
            end
         end else if (first_done == 0 && {hi, lo} !== prior) begin
            hold_bad = 1'b1;
         end
      end
      checkOutput("busy_start_done_count", 64'(done_cnt), 64'd1);
      checkOutput("busy_start_latency", 64'(first_done), 64'(busy_lat));
      checkOutput("busy_start_product", prod, busy_exp);
      checkOutput("busy_start_prior_held", {63'h0, hold_bad}, 64'h0);
      checkOutput("busy_start_final_hilo", {hi, lo}, busy_exp);

      // Reset mid-operation clears state immediately, and no done follows.
      applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (10) @(negedge clk);
      checkOutput("midop_busy_before_rst", {63'h0, busy}, 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("midop_rst_busy", {63'h0, busy}, 64'h0);
      checkOutput("midop_rst_hilo", {hi, lo}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      checkOutput("midop_no_done", 64'(done_cnt), 64'h0);

      runOp(1'b0, 32'd6, 32'd7, prod, lat, bcnt, tmo);
      checkOutput("after_rst_timeout", {63'h0, tmo}, 64'h0);
      checkOutput("after_rst_product", prod, 64'd42);
      checkOutput("after_rst_latency", 64'(lat), 64'(expLat(3)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
